text_writer: RTL and testbench

Host-side write engine for the text-mode video path: accepts a byte stream of characters and control codes and turns it into 16-bit cell writes into video RAM. It maintains the cursor, handles CR/LF/BS/FF, auto-wraps at end of line, and scrolls by moving a circular start address rather than copying memory. It sits opposite the display fetch path. The video controller reads cells from `start_addr`; the matrix uses `cursor_addr` for cursor blink. A VRAM write port grants this block's writes in slots that do not collide with video fetches.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/row_addr_mul.sv | 17 +
 rtl/text_writer.sv | 219 +++++++++++++++++++++
 tb/tb_text_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the text-mode video path (text writer, video
// controller, vram). Holds the screen geometry, VRAM address width,
// control codes, the space character and the power-up attribute.
package vga_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 13;
  localparam int CELLS  = COLS * ROWS;

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [7:0] CH_CR        = 8'h0D;
  localparam logic [7:0] CH_LF        = 8'h0A;
  localparam logic [7:0] CH_BS        = 8'h08;
  localparam logic [7:0] CH_FF        = 8'h0C;
  localparam logic [7:0] CH_SPACE     = 8'h20;
  localparam logic [7:0] ATTR_DEFAULT = 8'h07;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(CELLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_CLEAR_LINE = 2'd2,
    ST_CLEAR_ALL  = 2'd3
  } tw_state_t;

  // Row index increment with wrap at ROWS.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == ROW_LAST) ? '0 : r + 1'b1;
  endfunction

endpackage

// File: rtl/row_addr_mul.sv
// Row base address: row * COLS as shift-and-add (80 = 64 + 16).
// Ports:
//   row  - row index (0..ROWS-1)
//   base - row * COLS at ADDR_W bits
module row_addr_mul
  import vga_pkg::*;
(
  input  logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] base
);

  logic [ADDR_W-1:0] row_ext;

  assign row_ext = ADDR_W'(row);
  assign base    = (row_ext << 6) + (row_ext << 4);

endmodule

// File: rtl/text_writer.sv
// Text-mode write engine. Turns a byte stream of characters and control
// codes (CR, LF, BS, FF) into {attr, char} cell writes into VRAM, tracks the
// cursor, auto-wraps at end of line and scrolls by advancing a circular top
// row instead of moving memory.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   in_data/in_valid/in_ready - byte input handshake
//   attr                    - colour attribute, sampled with each accepted byte
//   wr_en/wr_addr/wr_data   - VRAM write request, held until wr_grant
//   wr_grant                - write slot granted by the VRAM arbiter
//   start_addr              - address of the top displayed row
//   cursor_addr             - address of the cursor cell
//   busy                    - high whenever not IDLE
//
// state         | meaning
// ST_IDLE       | ready for a byte; CR/BS/LF (no scroll) handled in place
// ST_WRITE      | one character write pending until granted
// ST_CLEAR_LINE | scroll: blanking the row that becomes the new bottom line
// ST_CLEAR_ALL  | form feed / reset: blanking the whole screen from address 0
module text_writer
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        attr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_grant,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  tw_state_t state, state_nxt;

  logic              armed_q;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  phys_row;
  logic [ROW_W-1:0]  log_row;
  logic [ROW_W-1:0]  top_row;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        attr_q;
  logic [7:0]        char_q;

  logic              accept;
  logic              xfer;
  logic              col_last;
  logic              log_last;
  logic              newline;
  logic              clr_line_done;
  logic              clr_all_done;
  logic [ADDR_W-1:0] cursor_base;
  logic [ADDR_W-1:0] start_base;

  row_addr_mul u_cursor_mul (
    .row  (phys_row),
    .base (cursor_base)
  );

  row_addr_mul u_start_mul (
    .row  (top_row),
    .base (start_base)
  );

  assign cursor_addr = cursor_base + ADDR_W'(col);
  assign start_addr  = start_base;

  assign accept   = in_valid && in_ready;
  assign xfer     = wr_en && wr_grant;
  assign col_last = (col == COL_LAST);
  assign log_last = (log_row == ROW_LAST);

  // Explicit LF, or a granted character write in the last column (auto-wrap).
  assign newline = ((state == ST_IDLE) && accept && (in_data == CH_LF)) ||
                   ((state == ST_WRITE) && xfer && col_last);

  assign clr_line_done = (state == ST_CLEAR_LINE) && xfer && (clr_cnt == LINE_LAST);
  assign clr_all_done  = (state == ST_CLEAR_ALL)  && xfer && (clr_cnt == CELL_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR_ALL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (in_data)
            CH_CR, CH_BS: state_nxt = ST_IDLE;
            CH_LF:        state_nxt = log_last ? ST_CLEAR_LINE : ST_IDLE;
            CH_FF:        state_nxt = ST_CLEAR_ALL;
            default:      state_nxt = ST_WRITE;
          endcase
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          state_nxt = (col_last && log_last) ? ST_CLEAR_LINE : ST_IDLE;
        end
      end
      ST_CLEAR_LINE: begin
        if (clr_line_done) state_nxt = ST_IDLE;
      end
      ST_CLEAR_ALL: begin
        if (clr_all_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR_ALL;
    endcase
  end

  // Output logic. The request is held off while armed_q is low so that the
  // outputs read as idle during reset; the clear starts on the first clock
  // after release.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = clr_cnt;
    wr_data  = {attr_q, CH_SPACE};
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_WRITE: begin
        wr_en   = armed_q;
        wr_addr = wr_addr_q;
        wr_data = {attr_q, char_q};
      end
      ST_CLEAR_LINE: begin
        wr_en   = armed_q;
        wr_addr = start_base + clr_cnt;
      end
      ST_CLEAR_ALL: begin
        wr_en   = armed_q;
        wr_addr = clr_cnt;
      end
      default: ;
    endcase
  end

  // Cursor, scroll and clear datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      col       <= '0;
      phys_row  <= '0;
      log_row   <= '0;
      top_row   <= '0;
      clr_cnt   <= '0;
      wr_addr_q <= '0;
      attr_q    <= ATTR_DEFAULT;
      char_q    <= CH_SPACE;
    end else begin
      armed_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            attr_q <= attr;
            case (in_data)
              CH_CR: col <= '0;
              CH_BS: if (col != '0) col <= col - 1'b1;
              CH_LF, CH_FF: ;
              default: begin
                char_q    <= in_data;
                wr_addr_q <= cursor_addr;
              end
            endcase
          end
        end
        ST_WRITE: begin
          if (xfer) col <= col_last ? '0 : col + 1'b1;
        end
        ST_CLEAR_LINE: begin
          if (clr_line_done) begin
            clr_cnt <= '0;
            top_row <= row_inc(top_row);
          end else if (xfer) begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_CLEAR_ALL: begin
          if (clr_all_done) begin
            clr_cnt  <= '0;
            col      <= '0;
            top_row  <= '0;
          end else if (xfer) begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      // Row bookkeeping; the scroll clear is started by the FSM. Once the
      // screen is full, log_row stays pinned at the bottom line.
      if (clr_all_done) begin
        phys_row <= '0;
        log_row  <= '0;
      end else if (newline) begin
        phys_row <= row_inc(phys_row);
        if (!log_last) log_row <= log_row + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_writer.sv
module tb_text_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_grant;
  logic [12:0] start_addr;
  logic [12:0] cursor_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [28:0] exp_q[$];
  logic        grant_mode = 1'b0;
  logic        prev_stall = 1'b0;

  int m_col, m_phys, m_log, m_top;

  text_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .attr        (attr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_grant    (wr_grant),
    .start_addr  (start_addr),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Grant: always high, or toggling every cycle to force stalls.
  initial begin
    wr_grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (grant_mode) wr_grant = ~wr_grant;
      else            wr_grant = 1'b1;
    end
  end

  // Scoreboard: every granted transfer must match the head of the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("hold_wr_en", wr_en, 1);
      if (wr_en && wr_grant) begin
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("wr_addr", wr_addr, exp_q[0][28:16]);
          check("wr_data", wr_data, exp_q[0][15:0]);
          void'(exp_q.pop_front());
        end
      end
      prev_stall <= wr_en && !wr_grant;
    end
  end

  task automatic push_wr(input int addr, input logic [15:0] data);
    exp_q.push_back({13'(addr), data});
  endtask

  task automatic push_clear_all(input logic [7:0] a);
    for (int i = 0; i < 2400; i++) push_wr(i, {a, 8'h20});
  endtask

  task automatic model_newline(input logic [7:0] a);
    m_phys = (m_phys + 1) % 30;
    if (m_log < 29) begin
      m_log++;
    end else begin
      for (int i = 0; i < 80; i++) push_wr(m_top * 80 + i, {a, 8'h20});
      m_top = (m_top + 1) % 30;
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
  task automatic send(input logic [7:0] b, input logic [7:0] a);
    for (int i = 0; i < 6000; i++) begin
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    check("in_ready_wait", in_ready, 1);
    in_data  = b;
    attr     = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    attr     = 8'hFF;
    case (b)
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col--;
      8'h0A: model_newline(a);
      8'h0C: begin
        push_clear_all(a);
        m_col = 0; m_phys = 0; m_log = 0; m_top = 0;
      end
      default: begin
        push_wr(m_phys * 80 + m_col, {a, b});
        if (m_col == 79) begin
          m_col = 0;
          model_newline(a);
        end else begin
          m_col++;
        end
      end
    endcase
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 6000; i++) begin
      if (in_ready && exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(tag, in_ready && (exp_q.size() == 0), 1);
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_cursor"}, cursor_addr, m_phys * 80 + m_col);
    check({tag, "_start"}, start_addr, m_top * 80);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 16'h0720);
    check({tag, "_start"}, start_addr, 0);
    check({tag, "_cursor"}, cursor_addr, 0);
    check({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    attr     = 8'h00;
    m_col = 0; m_phys = 0; m_log = 0; m_top = 0;

    // Reset state and power-up clear
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    push_clear_all(8'h07);
    rst_n = 1'b1;
    wait_idle("init_clear_done");
    check("init_in_ready", in_ready, 1);
    check_pos("init");

    // Single character with stalled grant
    grant_mode = 1'b1;
    send(8'h41, 8'h1E);
    check("a_wr_en_lat", wr_en, 1);
    check("a_busy", busy, 1);
    wait_idle("a_done");
    check_pos("a");

    // Full row 0 with wrap to row 1
    grant_mode = 1'b0;
    @(posedge clk);
    #1;
    send(8'h0D, 8'h07);
    check("cr_in_ready", in_ready, 1);
    send(8'h61, 8'h17);
    check("row_wr_en_lat", wr_en, 1);
    check("row_in_ready_n1", in_ready, 0);
    @(posedge clk);
    #1;
    check("row_in_ready_n2", in_ready, 1);
    for (int i = 1; i < 80; i++) send(8'h61 + 8'(i % 26), 8'(8'h10 + i));
    wait_idle("row_done");
    check_pos("wrap");

    // Line feeds to bottom, then one scroll
    for (int i = 0; i < 28; i++) send(8'h0A, 8'h07);
    wait_idle("lf_done");
    check_pos("bottom");
    send(8'h0A, 8'h07);
    wait_idle("scroll_done");
    check_pos("scroll");

    // CR, BS at col 0, "xy", BS
    send(8'h0D, 8'h07);
    wait_idle("cr2");
    check_pos("cr2");
    send(8'h08, 8'h07);
    check("bs_in_ready", in_ready, 1);
    wait_idle("bs0");
    check_pos("bs0");
    send(8'h78, 8'h4A);
    send(8'h79, 8'h4B);
    wait_idle("xy");
    check_pos("xy");
    send(8'h08, 8'h07);
    wait_idle("bs1");
    check_pos("bs1");

    // Auto-wrap on the bottom line scrolls with the last byte's attribute
    send(8'h0D, 8'h07);
    for (int i = 0; i < 79; i++) send(8'h30 + 8'(i % 10), 8'h21);
    send(8'h5A, 8'h2F);
    wait_idle("wrap_scroll");
    check_pos("wrap_scroll");

    // Form feed, reset mid-clear restarts from address 0
    send(8'h0C, 8'h35);
    for (int i = 0; i < 3000; i++) begin
      if (wr_en && wr_addr == 13'd500) break;
      @(posedge clk);
      #1;
    end
    check("ff_clear_reached", wr_addr, 500);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    m_col = 0; m_phys = 0; m_log = 0; m_top = 0;
    push_clear_all(8'h07);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle("ff_restart_done");
    check_pos("ff");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
